// File: rtl/i3c_pkg.sv
// Shared I3C definitions: CCC parser states, broadcast address and CCC code helpers.
package i3c_pkg;

    typedef enum logic [3:0] {
        CCC_IDLE,
        CCC_ADDR,
        CCC_CODE,
        CCC_DEFB,
        CCC_BC_DATA,
        CCC_DIR_SR,
        CCC_DIR_ADDR,
        CCC_DIR_DATA,
        CCC_IGNORE
    } ccc_parser_state_e;

    localparam logic [6:0] I3C_BCAST_ADDR    = 7'h7E;
    localparam logic [7:0] I3C_BCAST_RSTACT  = 8'h2A;
    localparam logic [7:0] I3C_DIRECT_RSTACT = 8'h9A;

    function automatic logic ccc_has_defining_byte(input logic [7:0] code);
        return (code == I3C_BCAST_RSTACT) || (code == I3C_DIRECT_RSTACT);
    endfunction

endpackage

// File: rtl/ccc_frame_parser.sv
// CCC frame parser: bus events -> code/defining-byte/data strobes, direct addressing, done/error.
// All outputs registered, one cycle after the causing input; no backpressure, bytes accepted every cycle.
module ccc_frame_parser
    import i3c_pkg::*;
#(
    parameter int MaxDataBytes = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       bus_start_i,
    input  logic       bus_stop_i,
    input  logic [7:0] bus_byte_i,
    input  logic       bus_byte_valid_i,
    input  logic       bus_parity_err_i,
    input  logic [6:0] target_addr_i,
    output logic [7:0] command_code_o,
    output logic       command_code_valid_o,
    output logic [7:0] defining_byte_o,
    output logic       defining_byte_valid_o,
    output logic [7:0] command_data_o,
    output logic       command_data_valid_o,
    output logic       ccc_addressed_o,
    output logic       ccc_rnw_o,
    output logic       ccc_done_o,
    output logic       ccc_error_o
);

    localparam int CntW = $clog2(MaxDataBytes + 1);

    ccc_parser_state_e state_q;
    logic [CntW-1:0]   data_cnt_q;
    logic              code_seen_q;

    logic byte_take;
    logic byte_err;
    logic is_data_state;
    logic is_bcast;

    // START/STOP in the same cycle drop the byte, so it is neither parsed nor checked.
    always_comb begin
        is_data_state = (state_q == CCC_BC_DATA) || (state_q == CCC_DIR_DATA);
        is_bcast      = (bus_byte_i == {I3C_BCAST_ADDR, 1'b0});
        byte_take     = bus_byte_valid_i && !bus_start_i && !bus_stop_i &&
                        (state_q != CCC_IDLE) && (state_q != CCC_IGNORE);
        byte_err      = byte_take && (bus_parity_err_i || (state_q == CCC_DIR_SR) ||
                        (is_data_state && (data_cnt_q == CntW'(MaxDataBytes))));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q               <= CCC_IDLE;
            data_cnt_q            <= '0;
            code_seen_q           <= 1'b0;
            command_code_o        <= 8'h00;
            command_code_valid_o  <= 1'b0;
            defining_byte_o       <= 8'h00;
            defining_byte_valid_o <= 1'b0;
            command_data_o        <= 8'h00;
            command_data_valid_o  <= 1'b0;
            ccc_addressed_o       <= 1'b0;
            ccc_rnw_o             <= 1'b0;
            ccc_done_o            <= 1'b0;
            ccc_error_o           <= 1'b0;
        end else begin
            command_code_valid_o  <= 1'b0;
            defining_byte_valid_o <= 1'b0;
            command_data_valid_o  <= 1'b0;
            ccc_done_o            <= 1'b0;
            ccc_error_o           <= 1'b0;

            if (bus_stop_i) begin
                // code_seen_q is cleared on error, so an errored frame ends silently.
                state_q         <= CCC_IDLE;
                ccc_done_o      <= code_seen_q;
                code_seen_q     <= 1'b0;
                ccc_addressed_o <= 1'b0;
                ccc_rnw_o       <= 1'b0;
            end else if (bus_start_i) begin
                if (state_q != CCC_IGNORE) begin
                    ccc_addressed_o <= 1'b0;
                    ccc_rnw_o       <= 1'b0;
                end
                case (state_q)
                    CCC_IGNORE: ;
                    CCC_BC_DATA: begin
                        state_q     <= CCC_ADDR;
                        ccc_done_o  <= code_seen_q;
                        code_seen_q <= 1'b0;
                    end
                    CCC_DIR_SR, CCC_DIR_ADDR, CCC_DIR_DATA: begin
                        state_q    <= CCC_DIR_ADDR;
                        data_cnt_q <= '0;
                    end
                    default: state_q <= CCC_ADDR;
                endcase
            end else if (byte_err) begin
                state_q         <= CCC_IGNORE;
                ccc_error_o     <= 1'b1;
                code_seen_q     <= 1'b0;
                ccc_addressed_o <= 1'b0;
            end else if (byte_take) begin
                case (state_q)
                    CCC_ADDR: begin
                        state_q    <= is_bcast ? CCC_CODE : CCC_IGNORE;
                        data_cnt_q <= '0;
                    end
                    CCC_CODE: begin
                        command_code_o       <= bus_byte_i;
                        command_code_valid_o <= 1'b1;
                        code_seen_q          <= 1'b1;
                        if (ccc_has_defining_byte(bus_byte_i)) state_q <= CCC_DEFB;
                        else if (bus_byte_i[7])                state_q <= CCC_DIR_SR;
                        else                                   state_q <= CCC_BC_DATA;
                    end
                    CCC_DEFB: begin
                        defining_byte_o       <= bus_byte_i;
                        defining_byte_valid_o <= 1'b1;
                        state_q <= command_code_o[7] ? CCC_DIR_SR : CCC_BC_DATA;
                    end
                    CCC_BC_DATA: begin
                        command_data_o       <= bus_byte_i;
                        command_data_valid_o <= 1'b1;
                        data_cnt_q           <= data_cnt_q + CntW'(1);
                    end
                    CCC_DIR_ADDR: begin
                        data_cnt_q <= '0;
                        if (is_bcast) begin
                            // Broadcast address after Sr closes this CCC and chains the next one.
                            state_q         <= CCC_CODE;
                            ccc_done_o      <= code_seen_q;
                            code_seen_q     <= 1'b0;
                            ccc_addressed_o <= 1'b0;
                        end else if (bus_byte_i[7:1] == target_addr_i) begin
                            state_q         <= CCC_DIR_DATA;
                            ccc_addressed_o <= 1'b1;
                            ccc_rnw_o       <= bus_byte_i[0];
                        end else begin
                            state_q         <= CCC_DIR_DATA;
                            ccc_addressed_o <= 1'b0;
                        end
                    end
                    CCC_DIR_DATA: begin
                        data_cnt_q <= data_cnt_q + CntW'(1);
                        if (ccc_addressed_o && !ccc_rnw_o) begin
                            command_data_o       <= bus_byte_i;
                            command_data_valid_o <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
